// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB pipeline register with a two-entry skid buffer, flush, a registered
// writeback-forwarding port and a saturating back-pressure counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held, out_valid=0, in_ready=1
// ST_ONE   | main slot holds head entry, in_ready=1
// ST_FULL  | main + skid slots hold entries, in_ready=0
module mem_wb_elastic_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_BITS  = 5,
    parameter int STALL_CNT_BITS = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_regWrite,
    input  logic                      in_memRead,
    input  logic [REG_ADDR_BITS-1:0]  in_rd,
    input  logic [DATA_WIDTH-1:0]     in_memory_data,
    input  logic [DATA_WIDTH-1:0]     in_ALU_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      wb_regWrite,
    output logic                      wb_memRead,
    output logic [REG_ADDR_BITS-1:0]  wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_memory_data,
    output logic [DATA_WIDTH-1:0]     wb_ALU_result,
    output logic                      fwd_write,
    output logic [REG_ADDR_BITS-1:0]  fwd_write_reg,
    output logic [DATA_WIDTH-1:0]     fwd_write_data,
    output logic [STALL_CNT_BITS-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_read;
        logic [REG_ADDR_BITS-1:0] rd;
        logic [DATA_WIDTH-1:0]    mem_data;
        logic [DATA_WIDTH-1:0]    alu;
    } entry_t;

    state_t                    state_q, state_d;
    entry_t                    main_q, main_d;
    entry_t                    skid_q, skid_d;
    entry_t                    in_entry;
    logic                      in_ready_q, in_ready_d;
    logic                      fwd_write_q, fwd_write_d;
    logic [REG_ADDR_BITS-1:0]  fwd_reg_q, fwd_reg_d;
    logic [DATA_WIDTH-1:0]     fwd_data_q, fwd_data_d;
    logic [STALL_CNT_BITS-1:0] stall_q, stall_d;
    logic                      valid_now;
    logic                      in_fire;
    logic                      out_fire;
    logic                      commit;

    always_comb begin
        in_entry = '{reg_write: in_regWrite, mem_read: in_memRead, rd: in_rd,
                     mem_data: in_memory_data, alu: in_ALU_result};
        valid_now = (state_q != ST_EMPTY);
        in_fire   = in_valid && in_ready_q;
        out_fire  = valid_now && out_ready;

        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_entry;
                end else if (in_fire) begin
                    skid_d  = in_entry;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        in_ready_d = (state_d != ST_FULL);

        // A commit in the flush cycle still reaches the bypass network.
        commit      = out_fire && main_q.reg_write && (main_q.rd != '0);
        fwd_write_d = commit;
        fwd_reg_d   = commit ? main_q.rd : fwd_reg_q;
        fwd_data_d  = commit ? (main_q.mem_read ? main_q.mem_data : main_q.alu) : fwd_data_q;

        stall_d = stall_q;
        if (valid_now && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            fwd_write_q <= 1'b0;
            fwd_reg_q   <= '0;
            fwd_data_q  <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            fwd_write_q <= fwd_write_d;
            fwd_reg_q   <= fwd_reg_d;
            fwd_data_q  <= fwd_data_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = valid_now;
    assign wb_regWrite    = valid_now && main_q.reg_write;
    assign wb_memRead     = main_q.mem_read;
    assign wb_rd          = main_q.rd;
    assign wb_memory_data = main_q.mem_data;
    assign wb_ALU_result  = main_q.alu;
    assign fwd_write      = fwd_write_q;
    assign fwd_write_reg  = fwd_reg_q;
    assign fwd_write_data = fwd_data_q;
    assign stall_count    = stall_q;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Bench for mem_wb_elastic_reg: directed scenarios plus random traffic, compared
// against a queue-based reference model; a 4-bit-counter copy checks saturation.
module tb_mem_wb_elastic_reg;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_regWrite, in_memRead, out_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_memory_data, in_ALU_result;

    logic        in_ready, out_valid, wb_regWrite, wb_memRead, fwd_write;
    logic [4:0]  wb_rd, fwd_write_reg;
    logic [31:0] wb_memory_data, wb_ALU_result, fwd_write_data;
    logic [15:0] stall_count;

    logic        s_in_ready, s_out_valid, s_wb_regWrite, s_wb_memRead, s_fwd_write;
    logic [4:0]  s_wb_rd, s_fwd_write_reg;
    logic [31:0] s_wb_memory_data, s_wb_ALU_result, s_fwd_write_data;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_wb_elastic_reg dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_regWrite(in_regWrite), .in_memRead(in_memRead), .in_rd(in_rd),
        .in_memory_data(in_memory_data), .in_ALU_result(in_ALU_result),
        .out_valid(out_valid), .out_ready(out_ready), .wb_regWrite(wb_regWrite),
        .wb_memRead(wb_memRead), .wb_rd(wb_rd), .wb_memory_data(wb_memory_data),
        .wb_ALU_result(wb_ALU_result), .fwd_write(fwd_write), .fwd_write_reg(fwd_write_reg),
        .fwd_write_data(fwd_write_data), .stall_count(stall_count)
    );

    mem_wb_elastic_reg #(.STALL_CNT_BITS(4)) dut4 (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_regWrite(in_regWrite), .in_memRead(in_memRead), .in_rd(in_rd),
        .in_memory_data(in_memory_data), .in_ALU_result(in_ALU_result),
        .out_valid(s_out_valid), .out_ready(out_ready), .wb_regWrite(s_wb_regWrite),
        .wb_memRead(s_wb_memRead), .wb_rd(s_wb_rd), .wb_memory_data(s_wb_memory_data),
        .wb_ALU_result(s_wb_ALU_result), .fwd_write(s_fwd_write), .fwd_write_reg(s_fwd_write_reg),
        .fwd_write_data(s_fwd_write_data), .stall_count(s_stall_count)
    );

    typedef struct {
        bit          rw;
        bit          mr;
        logic [4:0]  rd;
        logic [31:0] md;
        logic [31:0] alu;
    } ent_t;

    ent_t        mq[$];
    bit          m_fwd_w;
    logic [4:0]  m_fwd_reg;
    logic [31:0] m_fwd_data;
    int          m_stall, m_stall4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: a FIFO of at most two entries, advanced once per clock edge.
    task automatic model_step();
        bit   ov, of, inf;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_fwd_w = 0; m_fwd_reg = 0; m_fwd_data = 0; m_stall = 0; m_stall4 = 0;
            return;
        end
        ov  = mq.size() > 0;
        of  = ov && out_ready;
        inf = in_valid && (mq.size() < 2);
        if (of && mq[0].rw && mq[0].rd != 0) begin
            m_fwd_w    = 1;
            m_fwd_reg  = mq[0].rd;
            m_fwd_data = mq[0].mr ? mq[0].md : mq[0].alu;
        end else begin
            m_fwd_w = 0;
        end
        if (ov && !out_ready) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall4 < 15) m_stall4++;
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (of) void'(mq.pop_front());
            if (inf) begin
                e = '{rw: in_regWrite, mr: in_memRead, rd: in_rd, md: in_memory_data, alu: in_ALU_result};
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_all();
        bit v;
        v = mq.size() > 0;
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("wb_regWrite", 64'(wb_regWrite), 64'(v ? mq[0].rw : 1'b0));
        if (v) begin
            chk("wb_memRead", 64'(wb_memRead), 64'(mq[0].mr));
            chk("wb_rd", 64'(wb_rd), 64'(mq[0].rd));
            chk("wb_memory_data", 64'(wb_memory_data), 64'(mq[0].md));
            chk("wb_ALU_result", 64'(wb_ALU_result), 64'(mq[0].alu));
        end
        chk("fwd_write", 64'(fwd_write), 64'(m_fwd_w));
        chk("fwd_write_reg", 64'(fwd_write_reg), 64'(m_fwd_reg));
        chk("fwd_write_data", 64'(fwd_write_data), 64'(m_fwd_data));
        chk("stall_count", 64'(stall_count), 64'(m_stall));
        chk("stall_count4", 64'(s_stall_count), 64'(m_stall4));
        chk("in_ready4", 64'(s_in_ready), 64'(in_ready));
        chk("out_valid4", 64'(s_out_valid), 64'(out_valid));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_wb_fields"}, {wb_regWrite, wb_memRead, wb_rd, wb_memory_data}, 64'd0);
        chk({tag, "_wb_alu"}, 64'(wb_ALU_result), 64'd0);
        chk({tag, "_fwd"}, {fwd_write, fwd_write_reg, fwd_write_data}, 64'd0);
        chk({tag, "_stall"}, 64'(stall_count), 64'd0);
        chk({tag, "_stall4"}, 64'(s_stall_count), 64'd0);
    endtask

    task automatic drive(input bit v, input bit rw, input bit mr, input logic [4:0] rd,
                         input logic [31:0] md, input logic [31:0] alu);
        in_valid = v; in_regWrite = rw; in_memRead = mr; in_rd = rd;
        in_memory_data = md; in_ALU_result = alu;
    endtask

    initial begin
        reset = 1; flush = 0; out_ready = 0;
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        check_reset_values("reset");
        reset = 0;

        // Single ALU writeback, then its forwarding one edge later.
        out_ready = 1;
        drive(1, 1, 0, 5'd3, 32'h0, 32'h1234);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_wb_rd", 64'(wb_rd), 64'd3);
        cycle();
        chk("t1_fwd", {fwd_write, fwd_write_reg, fwd_write_data}, {1'b1, 5'd3, 32'h1234});

        // Back-pressure: A then B fill both slots, then drain in order.
        out_ready = 0;
        drive(1, 1, 0, 5'd10, 32'h0, 32'hAAAA);
        cycle();
        drive(1, 1, 0, 5'd11, 32'h0, 32'hBBBB);
        cycle();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        drive(1, 1, 0, 5'd12, 32'h0, 32'hCCCC);
        repeat (3) cycle();
        chk("bp_stall", 64'(stall_count), 64'd4);
        drive(0, 0, 0, 0, 0, 0);
        out_ready = 1;
        cycle();
        chk("bp_first", {fwd_write_reg, fwd_write_data, wb_rd}, {5'd10, 32'hAAAA, 5'd11});
        cycle();
        chk("bp_second", {fwd_write_reg, fwd_write_data, out_valid, in_ready}, {5'd11, 32'hBBBB, 1'b0, 1'b1});

        // Load selects memory data; rd=0 write is not forwarded.
        drive(1, 1, 1, 5'd7, 32'hDEADBEEF, 32'h40);
        cycle();
        drive(1, 1, 0, 5'd0, 32'h0, 32'h55);
        cycle();
        chk("load_fwd", {fwd_write, fwd_write_data}, {1'b1, 32'hDEADBEEF});
        drive(0, 0, 0, 0, 0, 0);
        chk("rd0_wb_rd", {out_valid, wb_rd, wb_regWrite}, {1'b1, 5'd0, 1'b1});
        cycle();
        chk("rd0_fwd", 64'(fwd_write), 64'd0);

        // Flush from FULL drops everything, including the offered entry.
        out_ready = 0;
        drive(1, 1, 0, 5'd20, 32'h0, 32'h2020);
        cycle();
        drive(1, 1, 0, 5'd21, 32'h0, 32'h2121);
        cycle();
        drive(1, 1, 0, 5'd22, 32'h0, 32'h2222);
        flush = 1;
        cycle();
        flush = 0;
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_state", {out_valid, in_ready}, {1'b0, 1'b1});
        out_ready = 1;
        cycle();
        chk("flush_none", {out_valid, fwd_write}, 64'd0);

        // Saturation of the 4-bit counter copy.
        out_ready = 0;
        drive(1, 1, 0, 5'd9, 32'h0, 32'h9);
        cycle();
        drive(1, 1, 0, 5'd8, 32'h0, 32'h8);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        repeat (20) cycle();
        chk("sat4", 64'(s_stall_count), 64'd15);

        // Reset from FULL with a nonzero counter.
        chk("pre_reset_full", 64'(in_ready), 64'd0);
        reset = 1;
        cycle();
        check_reset_values("reset_full");
        reset = 0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom, $urandom);
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            reset     = $urandom_range(0, 99) == 0;
            cycle();
        end
        reset = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
